// File: rtl/mux_n_skid.sv
// N:1 WIDTH-bit select mux with a registered valid/ready output stage.
// A 2-entry skid buffer (main M + skid S) lets in_ready be a pure flop.
module mux_n_skid #(
  parameter int WIDTH       = 32,
  parameter int NUM_IN      = 4,
  parameter int SEL_W       = $clog2(NUM_IN),
  parameter int DEFAULT_SEL = 0,
  parameter int ERRCNT_W    = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]        in_sel,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    flush,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_sel_err,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [ERRCNT_W-1:0]     err_count
);

  localparam logic [SEL_W:0] NUM_IN_EXT = (SEL_W + 1)'(NUM_IN);

  function automatic logic [ERRCNT_W-1:0] sat_inc(input logic [ERRCNT_W-1:0] v);
    return (&v) ? v : v + ERRCNT_W'(1);
  endfunction

  logic                sel_ok;
  logic [SEL_W-1:0]    beat_idx;
  logic [WIDTH-1:0]    beat_data;
  logic                accept;
  logic                drain;

  logic                m_valid_q, m_valid_d;
  logic [WIDTH-1:0]    m_data_q, m_data_d;
  logic                m_err_q, m_err_d;
  logic                s_valid_q, s_valid_d;
  logic [WIDTH-1:0]    s_data_q, s_data_d;
  logic                s_err_q, s_err_d;
  logic                in_ready_q, in_ready_d;
  logic [ERRCNT_W-1:0] err_count_q, err_count_d;

  // Select stage: resolve the beat and its error flag at acceptance.
  always_comb begin
    sel_ok    = ({1'b0, in_sel} < NUM_IN_EXT);
    beat_idx  = sel_ok ? in_sel : SEL_W'(DEFAULT_SEL);
    beat_data = '0;
    for (int k = 0; k < NUM_IN; k++) begin
      if (beat_idx == SEL_W'(k)) beat_data = in_data[k*WIDTH +: WIDTH];
    end
  end

  assign accept = in_valid && in_ready_q && !flush;
  assign drain  = m_valid_q && out_ready;

  always_comb begin
    m_valid_d   = m_valid_q;
    m_data_d    = m_data_q;
    m_err_d     = m_err_q;
    s_valid_d   = s_valid_q;
    s_data_d    = s_data_q;
    s_err_d     = s_err_q;
    err_count_d = (accept && !sel_ok) ? sat_inc(err_count_q) : err_count_q;
    if (flush) begin
      m_valid_d = 1'b0;
      s_valid_d = 1'b0;
    end else if (s_valid_q) begin
      if (drain) begin
        m_valid_d = 1'b1;
        m_data_d  = s_data_q;
        m_err_d   = s_err_q;
        s_valid_d = accept;
        if (accept) begin
          s_data_d = beat_data;
          s_err_d  = !sel_ok;
        end
      end
    end else if (drain || !m_valid_q) begin
      m_valid_d = accept;
      if (accept) begin
        m_data_d = beat_data;
        m_err_d  = !sel_ok;
      end
    end else if (accept) begin
      s_valid_d = 1'b1;
      s_data_d  = beat_data;
      s_err_d   = !sel_ok;
    end
    in_ready_d = !s_valid_d;
  end

  // Register stage: control and the visible output word reset; skid data does not.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid_q   <= 1'b0;
      m_data_q    <= '0;
      m_err_q     <= 1'b0;
      s_valid_q   <= 1'b0;
      in_ready_q  <= 1'b0;
      err_count_q <= '0;
    end else begin
      m_valid_q   <= m_valid_d;
      m_data_q    <= m_data_d;
      m_err_q     <= m_err_d;
      s_valid_q   <= s_valid_d;
      in_ready_q  <= in_ready_d;
      err_count_q <= err_count_d;
    end
  end

  always_ff @(posedge clk) begin
    s_data_q <= s_data_d;
    s_err_q  <= s_err_d;
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = m_valid_q;
  assign out_data    = m_data_q;
  assign out_sel_err = m_err_q;
  assign err_count   = err_count_q;

endmodule

// File: tb/tb_mux_n_skid.sv
// Directed bench for mux_n_skid: a default 4-input instance and a
// 3-input / 2-bit-error-counter instance sharing clock and reset.
module tb_mux_n_skid;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // Instance A: NUM_IN=4, WIDTH=32
  logic [127:0] in_data = '0;
  logic [1:0]   in_sel = '0;
  logic         in_valid = 1'b0, flush = 1'b0, out_ready = 1'b0;
  logic         in_ready, out_sel_err, out_valid;
  logic [31:0]  out_data;
  logic [7:0]   err_count;

  // Instance B: NUM_IN=3, ERRCNT_W=2
  logic [95:0]  in_data3 = '0;
  logic [1:0]   in_sel3 = '0;
  logic         in_valid3 = 1'b0, flush3 = 1'b0, out_ready3 = 1'b0;
  logic         in_ready3, out_sel_err3, out_valid3;
  logic [31:0]  out_data3;
  logic [1:0]   err_count3;

  int tests_run = 0;
  int fails = 0;

  mux_n_skid #(.WIDTH(32), .NUM_IN(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_sel(in_sel),
    .in_valid(in_valid), .in_ready(in_ready), .flush(flush),
    .out_data(out_data), .out_sel_err(out_sel_err), .out_valid(out_valid),
    .out_ready(out_ready), .err_count(err_count)
  );

  mux_n_skid #(.WIDTH(32), .NUM_IN(3), .ERRCNT_W(2)) dut3 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data3), .in_sel(in_sel3),
    .in_valid(in_valid3), .in_ready(in_ready3), .flush(flush3),
    .out_data(out_data3), .out_sel_err(out_sel_err3), .out_valid(out_valid3),
    .out_ready(out_ready3), .err_count(err_count3)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    tests_run++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    tests_run++; if (out_data !== 32'h0) begin fails++; $display("FAIL reset_out_data got=%h exp=0", out_data); end
    tests_run++; if (out_sel_err !== 1'b0) begin fails++; $display("FAIL reset_sel_err got=%b exp=0", out_sel_err); end
    tests_run++; if (err_count !== 8'd0) begin fails++; $display("FAIL reset_err_count got=%0d exp=0", err_count); end
    rst_n = 1'b1;
    tick();
    tests_run++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    tests_run++; if (in_ready3 !== 1'b1) begin fails++; $display("FAIL reset_in_ready3 got=%b exp=1", in_ready3); end
  endtask

  task automatic test_basic();
    logic [31:0] exp;
    in_data   = {32'h4, 32'h3, 32'h2, 32'h1};
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int s = 0; s < 4; s++) begin
      in_sel = 2'(s);
      exp    = 32'(s + 1);
      tick();
      tests_run++; if (out_valid !== 1'b1 || out_data !== exp) begin fails++; $display("FAIL basic_sel%0d got=%h/%b exp=%h/1", s, out_data, out_valid, exp); end
      tests_run++; if (in_ready !== 1'b1) begin fails++; $display("FAIL basic_in_ready%0d got=%b exp=1", s, in_ready); end
    end
    in_valid = 1'b0;
    tick();
    tests_run++; if (out_valid !== 1'b0) begin fails++; $display("FAIL basic_drain got=%b exp=0", out_valid); end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_sel    = 2'd2;
    tick();
    tests_run++; if (out_data !== 32'h3 || out_valid !== 1'b1) begin fails++; $display("FAIL bp_first got=%h/%b exp=3/1", out_data, out_valid); end
    tests_run++; if (in_ready !== 1'b1) begin fails++; $display("FAIL bp_ready_m got=%b exp=1", in_ready); end
    in_sel = 2'd3;
    tick();
    tests_run++; if (out_data !== 32'h3) begin fails++; $display("FAIL bp_hold got=%h exp=3", out_data); end
    tests_run++; if (in_ready !== 1'b0) begin fails++; $display("FAIL bp_ready_s got=%b exp=0", in_ready); end
    in_valid = 1'b0;
    tick();
    tests_run++; if (out_data !== 32'h3 || out_valid !== 1'b1) begin fails++; $display("FAIL bp_stall got=%h/%b exp=3/1", out_data, out_valid); end
    out_ready = 1'b1;
    tick();
    tests_run++; if (out_data !== 32'h4 || out_valid !== 1'b1) begin fails++; $display("FAIL bp_second got=%h/%b exp=4/1", out_data, out_valid); end
    tests_run++; if (in_ready !== 1'b1) begin fails++; $display("FAIL bp_ready_back got=%b exp=1", in_ready); end
    tick();
    tests_run++; if (out_valid !== 1'b0) begin fails++; $display("FAIL bp_empty got=%b exp=0", out_valid); end
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_sel    = 2'd0;
    tick();
    in_sel = 2'd1;
    tick();
    tests_run++; if (out_data !== 32'h1 || in_ready !== 1'b0) begin fails++; $display("FAIL flush_full got=%h/%b exp=1/0", out_data, in_ready); end
    flush  = 1'b1;
    in_sel = 2'd3;
    tick();
    tests_run++; if (out_valid !== 1'b0) begin fails++; $display("FAIL flush_valid got=%b exp=0", out_valid); end
    tests_run++; if (in_ready !== 1'b1) begin fails++; $display("FAIL flush_ready got=%b exp=1", in_ready); end
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    tests_run++; if (out_valid !== 1'b0) begin fails++; $display("FAIL flush_dropped got=%b exp=0", out_valid); end
    tests_run++; if (err_count !== 8'd0) begin fails++; $display("FAIL flush_err_count got=%0d exp=0", err_count); end
  endtask

  task automatic test_sel_err();
    in_data3   = {32'h3333, 32'h2222, 32'hDEAD};
    out_ready3 = 1'b1;
    in_valid3  = 1'b1;
    in_sel3    = 2'd3;
    tests_run++; if (err_count3 !== 2'd0) begin fails++; $display("FAIL selerr_pre got=%0d exp=0", err_count3); end
    tick();
    tests_run++; if (out_data3 !== 32'hDEAD || out_valid3 !== 1'b1) begin fails++; $display("FAIL selerr_data got=%h/%b exp=dead/1", out_data3, out_valid3); end
    tests_run++; if (out_sel_err3 !== 1'b1) begin fails++; $display("FAIL selerr_flag got=%b exp=1", out_sel_err3); end
    tests_run++; if (err_count3 !== 2'd1) begin fails++; $display("FAIL selerr_count got=%0d exp=1", err_count3); end
  endtask

  task automatic test_err_sat();
    logic [1:0] exp_cnt [4] = '{2'd2, 2'd3, 2'd3, 2'd3};
    for (int i = 0; i < 4; i++) begin
      tick();
      tests_run++; if (err_count3 !== exp_cnt[i]) begin fails++; $display("FAIL errsat_%0d got=%0d exp=%0d", i, err_count3, exp_cnt[i]); end
    end
    in_sel3 = 2'd2;
    tick();
    tests_run++; if (out_data3 !== 32'h3333 || out_sel_err3 !== 1'b0) begin fails++; $display("FAIL errsat_inrange got=%h/%b exp=3333/0", out_data3, out_sel_err3); end
    tests_run++; if (err_count3 !== 2'd3) begin fails++; $display("FAIL errsat_hold got=%0d exp=3", err_count3); end
    in_valid3 = 1'b0;
    tick();
  endtask

  task automatic test_async_reset();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_sel    = 2'd2;
    tick();
    in_valid = 1'b0;
    tests_run++; if (out_valid !== 1'b1 || out_data !== 32'h3) begin fails++; $display("FAIL areset_loaded got=%h/%b exp=3/1", out_data, out_valid); end
    #2;
    rst_n = 1'b0;
    #1;
    tests_run++; if (out_valid !== 1'b0) begin fails++; $display("FAIL areset_valid got=%b exp=0", out_valid); end
    tests_run++; if (out_data !== 32'h0) begin fails++; $display("FAIL areset_data got=%h exp=0", out_data); end
    tests_run++; if (err_count3 !== 2'd0) begin fails++; $display("FAIL areset_err_count3 got=%0d exp=0", err_count3); end
    tick();
    rst_n = 1'b1;
    tick();
    tests_run++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin fails++; $display("FAIL areset_recover got=%b/%b exp=1/0", in_ready, out_valid); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_flush();
    test_sel_err();
    test_err_sat();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
